// File: rtl/salsa_block_ctrl_pkg.sv
// Shared types, constants and the quarter-round helper for the Salsa20 block controller.
package salsa_block_ctrl_pkg;

    typedef logic [31:0] salsa_state_t [0:15];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } salsa_fsm_t;

    // "expand 32-byte k" and "expand 16-byte k" as little-endian words
    localparam logic [31:0] SIGMA_W [0:3] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
    localparam logic [31:0] TAU_W   [0:3] = '{32'h61707865, 32'h3120646e, 32'h79622d36, 32'h6b206574};

    function automatic logic [31:0] salsa_rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Returns {z3, z2, z1, z0} for inputs (y0, y1, y2, y3)
    function automatic logic [127:0] salsa_qr(input logic [31:0] y0, input logic [31:0] y1,
                                              input logic [31:0] y2, input logic [31:0] y3);
        logic [31:0] z0, z1, z2, z3;
        z1 = y1 ^ salsa_rotl(y0 + y3, 7);
        z2 = y2 ^ salsa_rotl(z1 + y0, 9);
        z3 = y3 ^ salsa_rotl(z2 + z1, 13);
        z0 = y0 ^ salsa_rotl(z3 + z2, 18);
        return {z3, z2, z1, z0};
    endfunction

endpackage

// File: rtl/salsa_doubleround.sv
// Combinational Salsa20 double round: column round followed by row round.
module salsa_doubleround
    import salsa_block_ctrl_pkg::*;
(
    input  salsa_state_t x_i,
    output salsa_state_t x_o
);

    salsa_state_t mid;

    // Column c touches words 5c, 5c+4, 5c+8, 5c+12 (mod 16), diagonal word first
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        localparam int A = (5 * gi) % 16;
        localparam int B = (5 * gi + 4) % 16;
        localparam int C = (5 * gi + 8) % 16;
        localparam int D = (5 * gi + 12) % 16;
        logic [127:0] q;
        assign q      = salsa_qr(x_i[A], x_i[B], x_i[C], x_i[D]);
        assign mid[A] = q[31:0];
        assign mid[B] = q[63:32];
        assign mid[C] = q[95:64];
        assign mid[D] = q[127:96];
    end

    // Row r starts at its diagonal word 5r and wraps within the row
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        localparam int A = 4 * gi + (gi % 4);
        localparam int B = 4 * gi + ((gi + 1) % 4);
        localparam int C = 4 * gi + ((gi + 2) % 4);
        localparam int D = 4 * gi + ((gi + 3) % 4);
        logic [127:0] q;
        assign q      = salsa_qr(mid[A], mid[B], mid[C], mid[D]);
        assign x_o[A] = q[31:0];
        assign x_o[B] = q[63:32];
        assign x_o[C] = q[95:64];
        assign x_o[D] = q[127:96];
    end

endmodule

// File: rtl/salsa_block_ctrl.sv
// Salsa20 keystream block sequencer: builds the initial state, iterates one double
// round per cycle, adds the initial state back and offers the block on valid/ready.
module salsa_block_ctrl
    import salsa_block_ctrl_pkg::*;
#(
    parameter int ROUNDS = 20  // even, >= 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic         key_256,
    input  logic [63:0]  nonce,
    input  logic         ctr_load,
    input  logic [63:0]  ctr_init,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [511:0] ks_data,
    output logic [63:0]  ctr_out,
    output logic         busy
);

    localparam int DR = ROUNDS / 2;
    localparam int CW = (DR > 1) ? $clog2(DR + 1) : 1;
    localparam logic [CW-1:0] LAST_RND = CW'(DR - 1);

    salsa_fsm_t    state_q;
    logic [CW-1:0] round_q;
    logic [63:0]   ctr_q;
    logic [511:0]  ks_data_q;
    logic          ks_valid_q;
    logic          busy_q;
    salsa_state_t  init_q;
    salsa_state_t  x_q;

    salsa_state_t  init_d;
    salsa_state_t  dr_out;
    logic [511:0]  ks_sum;
    logic [63:0]   ctr_sel;

    // A load in the same cycle as start applies to that very block
    assign ctr_sel = ctr_load ? ctr_init : ctr_q;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            init_d[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            init_d[5 * i]  = key_256 ? SIGMA_W[i] : TAU_W[i];
            init_d[1 + i]  = key[32 * i +: 32];
            init_d[11 + i] = key_256 ? key[128 + 32 * i +: 32] : key[32 * i +: 32];
        end
        init_d[6] = nonce[31:0];
        init_d[7] = nonce[63:32];
        init_d[8] = ctr_sel[31:0];
        init_d[9] = ctr_sel[63:32];
    end

    salsa_doubleround u_dr (
        .x_i (x_q),
        .x_o (dr_out)
    );

    // Final addition taps the last double round directly so OUT follows RUN without a gap
    for (genvar gi = 0; gi < 16; gi++) begin : g_sum
        assign ks_sum[32 * gi +: 32] = dr_out[gi] + init_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            round_q    <= '0;
            ctr_q      <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                init_q[i] <= '0;
                x_q[i]    <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctr_load) begin
                        ctr_q <= ctr_init;
                    end
                    if (start) begin
                        init_q  <= init_d;
                        x_q     <= init_d;
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x_q <= dr_out;
                    if (round_q == LAST_RND) begin
                        round_q    <= '0;
                        ks_data_q  <= ks_sum;
                        ks_valid_q <= 1'b1;
                        state_q    <= OUT;
                    end else begin
                        round_q <= round_q + 1'b1;
                    end
                end
                OUT: begin
                    if (ks_ready) begin
                        ks_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        ctr_q      <= ctr_q + 64'd1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ks_valid = ks_valid_q;
    assign ks_data  = ks_data_q;
    assign ctr_out  = ctr_q;
    assign busy     = busy_q;

endmodule
